multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Control unit for the multicycle variant of the team's MIPS-subset core. Sequences one shared ALU and one unified instruction/data memory over several cycles per instruction.
- Takes opcode, funct and the ALU zero flag from the datapath. Drives all mux selects, write enables and the ALU operation.
- Sits inside `top` next to the datapath. The existing memwrite/dataadr/writedata bench works unchanged, because sw still asserts memwrite for exactly one cycle.

Parameters:
SUPPORT_BNE, 1, when 1 the bne opcode (000101) is decoded; when 0 it is treated as illegal.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; sampled on the rising edge of clk
op  input  6  instruction[31:26], valid from DECODE onward
funct  input  6  instruction[5:0]
zero  input  1  ALU result == 0
pcen  output  1  PC register enable
memwrite  output  1  memory write strobe
irwrite  output  1  instruction register load
regwrite  output  1  register file write
iord  output  1  memory address select: 0 = PC, 1 = ALUOut
memtoreg  output  1  write-back data select: 0 = ALUOut, 1 = Data
regdst  output  1  destination select: 0 = rt, 1 = rd
alusrca  output  1  ALU A select: 0 = PC, 1 = A register
alusrcb  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
alucontrol  output  3  ALU operation
state_o  output  4  current state, for verification only

Behaviour:
- Moore FSM. Every output except pcen and alucontrol is a pure function of the current state. Unlisted outputs are 0 in each state.
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Reset: on a clk edge with reset=1 the state becomes FETCH. This applies from any state, including mid-instruction; the partial instruction is abandoned and no write is issued after the reset edge. While in FETCH, outputs are FETCH outputs.
- Per-state outputs:
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=1, pcwrite=1.
  - DECODE: alusrca=0, alusrcb=11, aluop=00.
  - MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01. Sets branch=1 for beq, or bne=1 for bne (the latched opcode selects which).
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH always goes to DECODE.
  - DECODE dispatches on op:
    - 100011 (lw) and 101011 (sw) go to MEMADR.
    - 000000 (R-type) goes to EXECUTE.
    - 000100 (beq), and 000101 (bne) when SUPPORT_BNE=1, go to BRANCH.
    - 001000 (addi) goes to ADDIEX.
    - 000010 (j) goes to JUMP.
    - Any other op goes to FETCH. This is an illegal-instruction skip: PC already advanced, no writes.
  - MEMADR goes to MEMRD if op=lw, else MEMWR.
  - Single-successor paths: MEMRD→MEMWB, EXECUTE→ALUWB, ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP all return to FETCH.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2.
- pcen = pcwrite | (branch & zero) | (bne & ~zero). This is combinational from state and zero, valid in the same cycle.
- alucontrol is combinational:
  - aluop 00 → 010 (add); aluop 01 → 110 (sub).
  - aluop 10 decodes funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - An unknown funct gives 010. No X ever propagates.
- memwrite and regwrite are never both 1. irwrite is 1 only in FETCH.

Test Plan:
- Reset held 3 cycles then released, with op=100011 presented at DECODE → state_o sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. memwrite stays 0 throughout.
- sw (op=101011) → states 0,1,2,5,0. memwrite=1 and iord=1 for exactly one cycle, in state 5.
- R-type op=0 with funct=101010 → alucontrol=111 in EXECUTE, regdst=1 in ALUWB. funct=110000 → alucontrol=010.
- beq with zero=1 in BRANCH → pcen=1 and pcsrc=01. Same with zero=0 → pcen=0. bne with zero=0 → pcen=1; rerun with SUPPORT_BNE=0 → states 0,1,0.
- j → states 0,1,11,0, with pcen=1 and pcsrc=10 in JUMP. Illegal op=111111 → 0,1,0 with no memwrite/regwrite pulse.
- Assert reset during MEMWR (lw/sw mid-flight) → next state_o=0. memwrite is 0 from the cycle after the reset edge. The next instruction fetch proceeds normally.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: a Moore FSM that sequences the shared
// ALU and unified memory. It also holds the main ALU-control decoder and the
// PC-enable logic.
module multicycle_controller #(
   parameter bit SUPPORT_BNE = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       memtoreg,
   output logic       regdst,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state_o
);

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StAddiEx  = 4'd9,
      StAddiWb  = 4'd10,
      StJump    = 4'd11
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;
   logic       bne;

   // State register; reset abandons any in-flight instruction.
   always_ff @(posedge clk) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = StDecode;
         StDecode: begin
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExecute;
               OpBeq:      state_d = StBranch;
               OpBne:      state_d = SUPPORT_BNE ? StBranch : StFetch;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJump;
               // Illegal opcode: PC already advanced in FETCH, just skip it.
               default:    state_d = StFetch;
            endcase
         end
         StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
         StMemRd:   state_d = StMemWb;
         StExecute: state_d = StAluWb;
         StAddiEx:  state_d = StAddiWb;
         default:   state_d = StFetch;
      endcase
   end

   // Moore outputs decoded from the current state only.
   always_comb begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      iord     = 1'b0;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bne      = 1'b0;
      case (state_q)
         StFetch: begin
            alusrcb = 2'b01;
            irwrite = 1'b1;
            pcwrite = 1'b1;
         end
         StDecode: alusrcb = 2'b11;
         StMemAdr, StAddiEx: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         StMemRd: iord = 1'b1;
         StMemWb: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         StMemWr: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         StExecute: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         StAluWb: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         StBranch: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = (op == OpBeq);
            bne     = SUPPORT_BNE && (op == OpBne);
         end
         StAddiWb: regwrite = 1'b1;
         StJump: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase
   end

   // ALU control decode; unknown combinations fall back to add.
   always_comb begin
      alucontrol = 3'b010;
      case (aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
   end

   assign pcen    = pcwrite | (branch & zero) | (bne & ~zero);
   assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: state sequences, per-state
// outputs, ALU decode, branch resolution and mid-instruction reset.
module tb_multicycle_controller;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_ADD = 6'b001000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BAD = 6'b111111;

   logic       clk, reset, zero;
   logic [5:0] op, funct;
   logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state_o;

   logic       nb_pcen, nb_memwrite, nb_irwrite, nb_regwrite, nb_iord, nb_memtoreg;
   logic       nb_regdst, nb_alusrca;
   logic [1:0] nb_alusrcb, nb_pcsrc;
   logic [2:0] nb_alucontrol;
   logic [3:0] nb_state_o;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_controller #(.SUPPORT_BNE(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
      .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state_o(state_o)
   );

   multicycle_controller #(.SUPPORT_BNE(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(nb_pcen), .memwrite(nb_memwrite), .irwrite(nb_irwrite),
      .regwrite(nb_regwrite), .iord(nb_iord), .memtoreg(nb_memtoreg),
      .regdst(nb_regdst), .alusrca(nb_alusrca), .alusrcb(nb_alusrcb),
      .pcsrc(nb_pcsrc), .alucontrol(nb_alucontrol), .state_o(nb_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] seq [5];
      seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      reset = 1'b1; op = OP_LW; zero = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if (state_o !== 4'd0 || nb_state_o !== 4'd0) begin
         n_err++; $display("FAIL reset_state got %0d/%0d want 0/0", state_o, nb_state_o);
      end
      n_cmp++;
      if ({irwrite, pcen, alusrcb, memwrite, regwrite, alucontrol} !== {1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3'b010}) begin
         n_err++; $display("FAIL reset_fetch_outs got %b%b%b%b%b%b want 11010 0 010", irwrite, pcen, alusrcb, memwrite, regwrite, alucontrol);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (state_o !== seq[i]) begin
            n_err++; $display("FAIL lw_state i=%0d got %0d want %0d", i, state_o, seq[i]);
         end
         n_cmp++;
         if (regwrite !== (seq[i] == 4'd4) || memtoreg !== (seq[i] == 4'd4) || memwrite !== 1'b0
             || iord !== (seq[i] == 4'd3)) begin
            n_err++; $display("FAIL lw_outs i=%0d got rw=%b mtr=%b mw=%b iord=%b", i, regwrite, memtoreg, memwrite, iord);
         end
      end
   endtask

   task automatic test_sw();
      logic [3:0] seq [4];
      int pulses = 0;
      seq = '{4'd1, 4'd2, 4'd5, 4'd0};
      op = OP_SW;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (memwrite === 1'b1) pulses++;
         n_cmp++;
         if (state_o !== seq[i]) begin
            n_err++; $display("FAIL sw_state i=%0d got %0d want %0d", i, state_o, seq[i]);
         end
         n_cmp++;
         if (memwrite !== (seq[i] == 4'd5) || iord !== (seq[i] == 4'd5) || regwrite !== 1'b0
             || irwrite !== (seq[i] == 4'd0)) begin
            n_err++; $display("FAIL sw_outs i=%0d got mw=%b iord=%b rw=%b ir=%b", i, memwrite, iord, regwrite, irwrite);
         end
      end
      n_cmp++;
      if (pulses !== 1) begin
         n_err++; $display("FAIL sw_pulses got %0d want 1", pulses);
      end
   endtask

   task automatic test_rtype();
      logic [5:0] fn [6];
      logic [2:0] ac [6];
      fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b110000};
      ac = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
      op = OP_R;
      for (int k = 0; k < 6; k++) begin
         funct = fn[k];
         tick();
         n_cmp++;
         if (state_o !== 4'd1 || alusrcb !== 2'b11 || alucontrol !== 3'b010) begin
            n_err++; $display("FAIL r_decode k=%0d got st=%0d srcb=%b ac=%b", k, state_o, alusrcb, alucontrol);
         end
         tick();
         n_cmp++;
         if (state_o !== 4'd6 || alucontrol !== ac[k] || alusrca !== 1'b1 || alusrcb !== 2'b00) begin
            n_err++; $display("FAIL r_exec k=%0d got st=%0d ac=%b want st=6 ac=%b", k, state_o, alucontrol, ac[k]);
         end
         tick();
         n_cmp++;
         if (state_o !== 4'd7 || regdst !== 1'b1 || regwrite !== 1'b1 || memtoreg !== 1'b0) begin
            n_err++; $display("FAIL r_wb k=%0d got st=%0d rd=%b rw=%b", k, state_o, regdst, regwrite);
         end
         tick();
         n_cmp++;
         if (state_o !== 4'd0) begin
            n_err++; $display("FAIL r_ret k=%0d got %0d want 0", k, state_o);
         end
      end
   endtask

   task automatic test_branch();
      logic [5:0] bop [4];
      logic       bz  [4];
      logic       bpc [4];
      bop = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
      bz  = '{1'b1,   1'b0,   1'b0,   1'b1};
      bpc = '{1'b1,   1'b0,   1'b1,   1'b0};
      for (int k = 0; k < 4; k++) begin
         op = bop[k]; zero = bz[k];
         tick();
         n_cmp++;
         if (state_o !== 4'd1 || pcen !== 1'b0) begin
            n_err++; $display("FAIL br_decode k=%0d got st=%0d pcen=%b", k, state_o, pcen);
         end
         if (bop[k] == OP_BNE) begin
            n_cmp++;
            if (nb_state_o !== 4'd1) begin
               n_err++; $display("FAIL nb_decode k=%0d got %0d want 1", k, nb_state_o);
            end
         end
         tick();
         n_cmp++;
         if (state_o !== 4'd8 || pcen !== bpc[k] || pcsrc !== 2'b01 || alucontrol !== 3'b110) begin
            n_err++; $display("FAIL br_exec k=%0d got st=%0d pcen=%b pcsrc=%b ac=%b want 8 %b 01 110", k, state_o, pcen, pcsrc, alucontrol, bpc[k]);
         end
         if (bop[k] == OP_BNE) begin
            n_cmp++;
            if (nb_state_o !== 4'd0 || nb_memwrite !== 1'b0 || nb_regwrite !== 1'b0) begin
               n_err++; $display("FAIL nb_skip k=%0d got st=%0d mw=%b rw=%b want 0", k, nb_state_o, nb_memwrite, nb_regwrite);
            end
         end
         tick();
         n_cmp++;
         if (state_o !== 4'd0) begin
            n_err++; $display("FAIL br_ret k=%0d got %0d want 0", k, state_o);
         end
         // Realign the SUPPORT_BNE=0 instance, whose path was one cycle shorter.
         if (bop[k] == OP_BNE) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
      end
      zero = 1'b0;
   endtask

   task automatic test_jump();
      op = OP_J;
      tick();
      tick();
      n_cmp++;
      if (state_o !== 4'd11 || pcen !== 1'b1 || pcsrc !== 2'b10 || irwrite !== 1'b0) begin
         n_err++; $display("FAIL j_exec got st=%0d pcen=%b pcsrc=%b ir=%b want 11 1 10 0", state_o, pcen, pcsrc, irwrite);
      end
      tick();
      n_cmp++;
      if (state_o !== 4'd0) begin
         n_err++; $display("FAIL j_ret got %0d want 0", state_o);
      end
   endtask

   task automatic test_addi();
      op = OP_ADD;
      tick();
      tick();
      n_cmp++;
      if (state_o !== 4'd9 || alusrca !== 1'b1 || alusrcb !== 2'b10 || alucontrol !== 3'b010) begin
         n_err++; $display("FAIL addi_ex got st=%0d a=%b b=%b ac=%b", state_o, alusrca, alusrcb, alucontrol);
      end
      tick();
      n_cmp++;
      if (state_o !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin
         n_err++; $display("FAIL addi_wb got st=%0d rw=%b rd=%b mtr=%b", state_o, regwrite, regdst, memtoreg);
      end
      tick();
      n_cmp++;
      if (state_o !== 4'd0) begin
         n_err++; $display("FAIL addi_ret got %0d want 0", state_o);
      end
   endtask

   task automatic test_illegal();
      op = OP_BAD;
      tick();
      n_cmp++;
      if (state_o !== 4'd1 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
         n_err++; $display("FAIL ill_decode got st=%0d mw=%b rw=%b", state_o, memwrite, regwrite);
      end
      tick();
      n_cmp++;
      if (state_o !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0 || irwrite !== 1'b1) begin
         n_err++; $display("FAIL ill_skip got st=%0d mw=%b rw=%b ir=%b want 0 0 0 1", state_o, memwrite, regwrite, irwrite);
      end
   endtask

   task automatic test_reset_midflight();
      logic [3:0] seq [5];
      seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      op = OP_SW;
      repeat (3) tick();
      n_cmp++;
      if (state_o !== 4'd5 || memwrite !== 1'b1) begin
         n_err++; $display("FAIL mid_sw_pre got st=%0d mw=%b want 5 1", state_o, memwrite);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if (state_o !== 4'd0 || memwrite !== 1'b0) begin
         n_err++; $display("FAIL mid_sw_rst got st=%0d mw=%b want 0 0", state_o, memwrite);
      end
      reset = 1'b0;
      op = OP_LW;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (state_o !== seq[i] || memwrite !== 1'b0) begin
            n_err++; $display("FAIL mid_refetch i=%0d got st=%0d mw=%b want %0d 0", i, state_o, memwrite, seq[i]);
         end
      end
      repeat (3) tick();
      n_cmp++;
      if (state_o !== 4'd3) begin
         n_err++; $display("FAIL mid_lw_pre got %0d want 3", state_o);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (state_o !== 4'd0 || regwrite !== 1'b0) begin
         n_err++; $display("FAIL mid_lw_rst got st=%0d rw=%b want 0 0", state_o, regwrite);
      end
      tick();
      n_cmp++;
      if (state_o !== 4'd1 || regwrite !== 1'b0) begin
         n_err++; $display("FAIL mid_lw_after got st=%0d rw=%b want 1 0", state_o, regwrite);
      end
   endtask

   initial begin
      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
      test_reset();
      test_sw();
      test_rtype();
      test_branch();
      test_jump();
      test_addi();
      test_illegal();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
